sys_ctrl_rx_cmd: RTL

//   Command decoder directly downstream of the UART receiver. Consumes validated RX bytes
//   (one-cycle data_valid strobe per frame) and runs a multi-byte command protocol.

---
 rtl/sys_ctrl_rx_cmd.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_rx_cmd.sv
// Command decoder that sits directly after the UART receiver.
// It collects validated RX bytes into multi-byte commands, drives register-file
// writes and reads and ALU starts, and returns read or ALU results to the UART
// transmitter through a push/busy handshake.
//
// Ports:
//   clk, rstn                  system clock; asynchronous active-low reset
//   rx_p_data, rx_d_valid      received byte and its one-cycle valid strobe
//   rf_rd_data, rf_rd_valid    register-file read response
//   alu_out, alu_out_valid     ALU result and its one-cycle valid strobe
//   tx_busy                    transmitter busy; a push is only made while it is low
//   rf_addr, rf_wr_en,
//   rf_wr_data, rf_rd_en       register-file access
//   alu_en, alu_fun            ALU start strobe and function select (held)
//   clk_gate_en                ALU clock-gate enable
//   tx_p_data, tx_d_valid      byte to transmit and its one-cycle push strobe
//   cmd_error                  one-cycle strobe for an unknown opcode
module sys_ctrl_rx_cmd #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned ALU_FUN_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_WIDTH-1:0]    rx_p_data,
  input  logic                     rx_d_valid,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data,
  input  logic                     rf_rd_valid,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out,
  input  logic                     alu_out_valid,
  input  logic                     tx_busy,
  output logic [ADDR_WIDTH-1:0]    rf_addr,
  output logic                     rf_wr_en,
  output logic [DATA_WIDTH-1:0]    rf_wr_data,
  output logic                     rf_rd_en,
  output logic                     alu_en,
  output logic [ALU_FUN_WIDTH-1:0] alu_fun,
  output logic                     clk_gate_en,
  output logic [DATA_WIDTH-1:0]    tx_p_data,
  output logic                     tx_d_valid,
  output logic                     cmd_error
);

  localparam logic [DATA_WIDTH-1:0] OpWr      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OpRd      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OpAluOp   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OpAluNoOp = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StAluA,
    StAluB,
    StAluFun,
    StAluWait,
    StTxB0,
    StTxWait,
    StTxB1
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]    rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
  logic                     clk_gate_q, clk_gate_d;
  logic [DATA_WIDTH-1:0]    tx_p_data_q, tx_p_data_d;
  logic                     rf_wr_en_q, rf_wr_en_d;
  logic                     rf_rd_en_q, rf_rd_en_d;
  logic                     alu_en_q, alu_en_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     cmd_error_q, cmd_error_d;

  // Reply buffer and handshake bookkeeping.
  logic [DATA_WIDTH-1:0]    byte0_q, byte0_d;
  logic [DATA_WIDTH-1:0]    byte1_q, byte1_d;
  logic                     two_byte_q, two_byte_d;   // reply carries byte1 as well
  logic                     second_q, second_d;       // push in flight is byte1
  logic                     seen_busy_q, seen_busy_d; // busy seen high since the last push

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    clk_gate_d   = clk_gate_q;
    tx_p_data_d  = tx_p_data_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    two_byte_d   = two_byte_q;
    second_d     = second_q;
    seen_busy_d  = seen_busy_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_valid_d   = 1'b0;
    cmd_error_d  = 1'b0;

    // The gate drops the cycle after the result arrives; a new ALU opcode below overrides.
    if (alu_out_valid) begin
      clk_gate_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_d_valid) begin
          if (rx_p_data == OpWr) begin
            state_d = StWrAddr;
          end else if (rx_p_data == OpRd) begin
            state_d = StRdAddr;
          end else if (rx_p_data == OpAluOp) begin
            state_d    = StAluA;
            clk_gate_d = 1'b1;
          end else if (rx_p_data == OpAluNoOp) begin
            state_d    = StAluFun;
            clk_gate_d = 1'b1;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      StWrAddr: begin
        if (rx_d_valid) begin
          rf_addr_d = rx_p_data[ADDR_WIDTH-1:0];
          state_d   = StWrData;
        end
      end
      StWrData: begin
        if (rx_d_valid) begin
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StIdle;
        end
      end
      StRdAddr: begin
        if (rx_d_valid) begin
          rf_addr_d  = rx_p_data[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        if (rf_rd_valid) begin
          byte0_d    = rf_rd_data;
          two_byte_d = 1'b0;
          state_d    = StTxB0;
        end
      end
      StAluA: begin
        if (rx_d_valid) begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StAluB;
        end
      end
      StAluB: begin
        if (rx_d_valid) begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StAluFun;
        end
      end
      StAluFun: begin
        if (rx_d_valid) begin
          alu_fun_d = rx_p_data[ALU_FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = StAluWait;
        end
      end
      StAluWait: begin
        if (alu_out_valid) begin
          byte0_d    = alu_out[DATA_WIDTH-1:0];
          byte1_d    = alu_out[DATA_WIDTH +: DATA_WIDTH];
          two_byte_d = 1'b1;
          state_d    = StTxB0;
        end
      end
      StTxB0: begin
        if (!tx_busy) begin
          tx_p_data_d = byte0_q;
          tx_valid_d  = 1'b1;
          second_d    = 1'b0;
          seen_busy_d = 1'b0;
          state_d     = StTxWait;
        end
      end
      StTxWait: begin
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = (two_byte_q && !second_q) ? StTxB1 : StIdle;
        end
      end
      StTxB1: begin
        if (!tx_busy) begin
          tx_p_data_d = byte1_q;
          tx_valid_d  = 1'b1;
          second_d    = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = StTxWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_fun_q    <= '0;
      clk_gate_q   <= 1'b0;
      tx_p_data_q  <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      cmd_error_q  <= 1'b0;
      byte0_q      <= '0;
      byte1_q      <= '0;
      two_byte_q   <= 1'b0;
      second_q     <= 1'b0;
      seen_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_fun_q    <= alu_fun_d;
      clk_gate_q   <= clk_gate_d;
      tx_p_data_q  <= tx_p_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
      tx_valid_q   <= tx_valid_d;
      cmd_error_q  <= cmd_error_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      two_byte_q   <= two_byte_d;
      second_q     <= second_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

  assign rf_addr     = rf_addr_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign rf_rd_en    = rf_rd_en_q;
  assign alu_en      = alu_en_q;
  assign alu_fun     = alu_fun_q;
  assign clk_gate_en = clk_gate_q;
  assign tx_p_data   = tx_p_data_q;
  assign tx_d_valid  = tx_valid_q;
  assign cmd_error   = cmd_error_q;

endmodule
